quad_enc_gen: RTL and testbench

//  Synthetic rotary-encoder source: turns step/press commands into debounce-safe quadrature A/B
//  and active-low switch waveforms. Mirror of the encoder decoder. Drives the encoder

---
 rtl/qenc_pkg.sv | 18 +
 rtl/quad_enc_gen_if.sv | 14 +
 rtl/qenc_phase_timer.sv | 35 +++
 rtl/quad_enc_gen.sv | 127 ++++++++++++
 tb/tb_quad_enc_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qenc_pkg.sv
// Shared types and quadrature phase tables for the synthetic rotary-encoder source.
package qenc_pkg;

    typedef enum logic [2:0] {IDLE, STEP, SETTLE, PRESS, GAP, FIN} qenc_state_t;

    localparam logic [1:0] DETENT = 2'b11;

    // Entry 0 sits in the low bits; phase 0 is always the detent level.
    localparam logic [7:0] GRAY_CW  = {2'b01, 2'b00, 2'b10, 2'b11};
    localparam logic [7:0] GRAY_CCW = {2'b10, 2'b00, 2'b01, 2'b11};

    function automatic logic [1:0] gray_ab(input logic dir, input logic [1:0] phase);
        logic [7:0] tbl;
        tbl = dir ? GRAY_CW : GRAY_CCW;
        return tbl[{phase, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/quad_enc_gen_if.sv
// Command handshake bundle for quad_enc_gen: valid/ready plus the latched command fields.
interface quad_enc_gen_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_press;

    modport master (output cmd_valid, cmd_dir, cmd_count, cmd_press, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_count, cmd_press, output cmd_ready);

endinterface

// File: rtl/qenc_phase_timer.sv
// Loadable down-counter that flags the last cycle of a loaded interval with a one-cycle tick.
module qenc_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         running;

    // A load of N gives N+1 cycles; expire is high during the last one.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign expire = running && (cnt == '0);

endmodule

// File: rtl/quad_enc_gen.sv
// Synthetic rotary encoder: turns step/press commands into detented quadrature A/B
// and an active-low switch, tracking a signed running detent position.
module quad_enc_gen
    import qenc_pkg::*;
#(
    parameter int PHASE_CYCLES = 50000,
    parameter int PRESS_CYCLES = 500000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    quad_enc_gen_if.slave    cmd,
    input  logic             abort,
    output logic             enc_a,
    output logic             enc_b,
    output logic             enc_sw,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position
);

    localparam int TMAX = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = CNT_W + 2;
    localparam logic [TW-1:0]    PHASE_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0]    PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] POS_ONE    = CNT_W'(1);

    qenc_state_t   state;
    qenc_state_t   next_state;
    logic          accept;
    logic          kill;
    logic          expire;
    logic          step_tick;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          dir_q;
    logic          press_q;
    logic [RW-1:0] remaining;
    logic [1:0]    phase;

    assign accept    = (state == IDLE) && cmd.cmd_valid;
    assign kill      = abort && (state != IDLE);
    assign step_tick = (state == STEP) && expire && !kill;

    // Every timed state starts its interval either from IDLE or on the tick ending the previous one.
    assign timer_load = ((state == IDLE) || expire) &&
                        (next_state inside {STEP, SETTLE, PRESS, GAP});
    assign timer_val  = (next_state inside {STEP, SETTLE}) ? PHASE_LOAD : PRESS_LOAD;

    qenc_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (kill),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_count != '0) begin
                        next_state = STEP;
                    end else if (cmd.cmd_press) begin
                        next_state = PRESS;
                    end else begin
                        next_state = FIN;
                    end
                end
            end
            STEP:   if (expire && (remaining == RW'(1))) next_state = SETTLE;
            SETTLE: if (expire) next_state = press_q ? PRESS : FIN;
            PRESS:  if (expire) next_state = GAP;
            GAP:    if (expire) next_state = FIN;
            FIN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (kill) begin
            next_state = IDLE;
        end
    end

    // Position only moves when a full detent closes, so an aborted partial detent never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= 1'b0;
            press_q   <= 1'b0;
            remaining <= '0;
            phase     <= 2'd0;
            position  <= '0;
        end else if (accept) begin
            dir_q     <= cmd.cmd_dir;
            press_q   <= cmd.cmd_press;
            remaining <= {cmd.cmd_count, 2'b00};
            phase     <= 2'd0;
        end else if (kill) begin
            remaining <= '0;
            phase     <= 2'd0;
        end else if (step_tick) begin
            phase     <= phase + 2'd1;
            remaining <= remaining - RW'(1);
            if (phase == 2'd3) begin
                position <= dir_q ? position + POS_ONE : position - POS_ONE;
            end
        end
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        busy          = (state != IDLE);
        done          = (state == FIN);
        enc_sw        = (state != PRESS);
        {enc_a, enc_b} = (state == STEP) ? gray_ab(dir_q, phase) : DETENT;
    end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Self-checking bench for quad_enc_gen: directed and randomized commands against a
// closed-form timing model plus an independent quadrature decoder for loopback.
module tb_quad_enc_gen;

    localparam int P    = 4;
    localparam int PR   = 8;
    localparam int CW_N = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            abort;
    logic            enc_a;
    logic            enc_b;
    logic            enc_sw;
    logic            busy;
    logic            done;
    logic [CW_N-1:0] position;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] pos_model;
    logic [15:0] dec_pos;
    logic [1:0]  prev_ab;
    logic [1:0]  cw_seq  [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0]  ccw_seq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    quad_enc_gen_if #(.CNT_W(CW_N)) cmd_if ();

    quad_enc_gen #(
        .PHASE_CYCLES (P),
        .PRESS_CYCLES (PR),
        .CNT_W        (CW_N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .abort    (abort),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_sw   (enc_sw),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic dir, input logic [15:0] count,
                                 input logic press);
        cmd_if.cmd_valid = valid;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_count = count;
        cmd_if.cmd_press = press;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int finTime(input int count, input bit press);
        int press_at;
        press_at = (count > 0) ? 4 * count * P + P : 0;
        return press ? press_at + 2 * PR : press_at;
    endfunction

    // Expected outputs t cycles after the accept edge, straight from the interval arithmetic.
    task automatic refModel(input int t, input bit dir, input int count, input bit press,
                            input logic [15:0] pos0, output logic [1:0] ab, output logic sw,
                            output logic dn, output logic bsy, output logic [15:0] pos);
        int k;
        int press_at;
        int fin_at;
        k = t / P;
        if (k > 4 * count) k = 4 * count;
        press_at = (count > 0) ? 4 * count * P + P : 0;
        fin_at   = finTime(count, press);
        ab  = dir ? cw_seq[k % 4] : ccw_seq[k % 4];
        pos = dir ? pos0 + 16'(k / 4) : pos0 - 16'(k / 4);
        sw  = !(press && (t >= press_at) && (t < press_at + PR));
        dn  = (t == fin_at);
        bsy = (t <= fin_at);
    endtask

    task automatic trackDecoder();
        logic [1:0] cur;
        cur = {enc_a, enc_b};
        if (cur != prev_ab) begin
            checkOutput("gray_one_bit", $countones(cur ^ prev_ab), 1);
            if (cur == 2'b11 && prev_ab == 2'b01) dec_pos = dec_pos + 16'd1;
            else if (cur == 2'b11 && prev_ab == 2'b10) dec_pos = dec_pos - 16'd1;
        end
        prev_ab = cur;
    endtask

    task automatic runCommand(input bit dir, input int count, input bit press, input int abort_at);
        logic [1:0]  e_ab;
        logic        e_sw;
        logic        e_done;
        logic        e_busy;
        logic [15:0] e_pos;
        logic [15:0] pos0;
        int          fin_at;
        bit          aborted;
        pos0    = pos_model;
        fin_at  = finTime(count, press);
        aborted = 1'b0;
        checkOutput("ready_before_cmd", cmd_if.cmd_ready, 1);
        applyStimulus(1'b1, dir, 16'(count), press);
        tick();
        // Valid stays high with different fields; none of it may be taken while busy.
        applyStimulus(1'b1, ~dir, 16'($urandom_range(1, 7)), ~press);
        for (int t = 0; t <= fin_at; t++) begin
            refModel(t, dir, count, press, pos0, e_ab, e_sw, e_done, e_busy, e_pos);
            checkOutput("enc_ab", {enc_a, enc_b}, e_ab);
            checkOutput("enc_sw", enc_sw, e_sw);
            checkOutput("done", done, e_done);
            checkOutput("busy", busy, e_busy);
            checkOutput("position", position, e_pos);
            trackDecoder();
            if (t == abort_at) begin
                applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checkOutput("abort_idle", cmd_if.cmd_ready, 1);
                checkOutput("abort_ab", {enc_a, enc_b}, 2'b11);
                checkOutput("abort_sw", enc_sw, 1);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_position", position, e_pos);
                prev_ab   = {enc_a, enc_b};
                pos_model = e_pos;
                aborted   = 1'b1;
                tick();
                checkOutput("abort_no_done", done, 0);
                break;
            end
            if (t == fin_at) applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
            tick();
        end
        if (!aborted) begin
            checkOutput("ready_after_done", cmd_if.cmd_ready, 1);
            checkOutput("done_one_cycle", done, 0);
            pos_model = dir ? pos0 + 16'(count) : pos0 - 16'(count);
            checkOutput("final_position", position, pos_model);
        end
        checkOutput("loopback_position", dec_pos, pos_model);
    endtask

    initial begin
        bit r_dir;
        bit r_press;
        int r_count;
        int r_fin;
        int r_abort;

        rst       = 1'b1;
        abort     = 1'b0;
        pos_model = 16'd0;
        dec_pos   = 16'd0;
        prev_ab   = 2'b11;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_ab", {enc_a, enc_b}, 2'b11);
        checkOutput("reset_sw", enc_sw, 1);
        checkOutput("reset_ready", cmd_if.cmd_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_position", position, 0);

        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        checkOutput("idle_abort_ignored", busy, 0);

        runCommand(1'b0, 2, 1'b0, -1);
        runCommand(1'b1, 1, 1'b0, -1);
        runCommand(1'b0, 0, 1'b1, -1);
        runCommand(1'b1, 0, 1'b0, -1);
        runCommand(1'b1, 3, 1'b0, 6);
        runCommand(1'b0, 65535, 1'b0, 20);
        runCommand(1'b1, 1, 1'b1, -1);

        // Accept and abort together in IDLE: the command wins.
        applyStimulus(1'b1, 1'b1, 16'd0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("valid_with_abort_done", done, 1);
        tick();
        checkOutput("valid_with_abort_ready", cmd_if.cmd_ready, 1);

        applyStimulus(1'b1, 1'b1, 16'd2, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            checkOutput("pre_reset_busy", busy, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_step_ab", {enc_a, enc_b}, 2'b11);
        checkOutput("rst_mid_step_sw", enc_sw, 1);
        checkOutput("rst_mid_step_position", position, 0);
        checkOutput("rst_mid_step_ready", cmd_if.cmd_ready, 1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("rst_no_done", done, 0);
        end
        pos_model = 16'd0;
        dec_pos   = 16'd0;
        prev_ab   = 2'b11;

        for (int i = 0; i < 10; i++) begin
            r_dir   = 1'($urandom_range(0, 1));
            r_press = 1'($urandom_range(0, 1));
            r_count = $urandom_range(0, 3);
            r_fin   = finTime(r_count, r_press);
            r_abort = -1;
            if (r_fin > 0 && $urandom_range(0, 2) == 0) r_abort = $urandom_range(0, r_fin - 1);
            runCommand(r_dir, r_count, r_press, r_abort);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
